fifo_drain: RTL
===============

FIFO_DRAIN -- requirements
Module: fifo_drain

Interface
REQ-001 SHALL have parameter DWIDTH, default 32: data word width, equal to the upstream FIFO word width.
REQ-002 SHALL have parameter BURST_LEN, default 4: number of words per output burst; legal range 2..256.
REQ-003 SHALL have port Clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port RstN  input  1  reset, asynchronous assertion, active-low.
REQ-005 SHALL have port F_Data  input  DWIDTH  upstream FIFO read data, valid combinationally at the current read pointer.
REQ-006 SHALL have port F_EmptyN  input  1  upstream FIFO not-empty flag, high when at least one word is stored.
REQ-007 SHALL have port FOutN  output  1  upstream FIFO read strobe, active-low; one word is consumed per rising edge with FOutN low.
REQ-008 SHALL have port DClrN  input  1  synchronous clear, active-low.
REQ-009 SHALL have port Out_Data  output  DWIDTH  downstream data.
REQ-010 SHALL have port Out_Valid  output  1  Out_Data/Out_Sop/Out_Eop valid.
REQ-011 SHALL have port Out_Ready  input  1  downstream accepts the word when high together with Out_Valid.
REQ-012 SHALL have port Out_Sop  output  1  first word of a burst.
REQ-013 SHALL have port Out_Eop  output  1  last word of a burst.

Function
REQ-014 SHALL hold words in a 2-entry in-order output buffer with states EMPTY, ONE and TWO.
- State transitions: push only: EMPTY->ONE, ONE->TWO. Pop only: TWO->ONE, ONE->EMPTY. Push and pop together: state unchanged.
REQ-015 SHALL drive FOutN low combinationally when all of the following hold; otherwise FOutN is high:
- F_EmptyN=1
- DClrN=1
- buffer state is EMPTY, or ONE, or TWO with Out_Ready=1
REQ-016 SHALL capture F_Data into the buffer tail on every rising edge with FOutN low (push).
REQ-017 SHALL drive Out_Data, Out_Sop and Out_Eop from the buffer head; Out_Valid=1 exactly when the state is not EMPTY.
REQ-018 SHALL remove the head on a rising edge with Out_Valid=1 and Out_Ready=1 (pop).
REQ-019 SHALL have a latency of one cycle: a word popped from upstream in cycle N is presented on Out_Data in cycle N+1 when the buffer was EMPTY.
REQ-020 SHALL sustain one word per cycle when F_EmptyN and Out_Ready are held high.
REQ-021 SHALL hold Out_Data, Out_Sop and Out_Eop stable while Out_Valid=1 and Out_Ready=0.
REQ-022 SHALL tag words using a beat counter of width clog2(BURST_LEN).
- The counter advances on each push and wraps from BURST_LEN-1 to 0.
- Sop is stored with the word when the counter is 0; Eop is stored when the counter is BURST_LEN-1.
REQ-023 SHALL never issue a read while F_EmptyN=0, and never overflow or underflow the buffer.
REQ-024 SHALL, when DClrN=0 at a rising edge, force the buffer to EMPTY and the beat counter to 0, discarding held words; FOutN stays high during the clear.

Reset
REQ-025 SHALL, while RstN=0, force the buffer to EMPTY and the beat counter to 0, so that Out_Valid=0, Out_Sop=0, Out_Eop=0, Out_Data=0 and FOutN=1.
REQ-026 SHALL discard buffered words and any partial burst when reset is asserted mid-burst; the first word after reset carries Sop.

Configuration
REQ-027 SHALL, with macro FIFO_DRAIN_PARITY_EN defined, add output port Out_Par (1 bit).
- Out_Par is the odd parity of the head word, computed at push and stored per entry.
- Out_Par is 0 at reset and while the buffer is EMPTY.
REQ-028 SHALL, without FIFO_DRAIN_PARITY_EN, omit the Out_Par port and all parity storage; behaviour is otherwise identical.

Verification
REQ-029 SHALL cover streaming.
- Stimulus: upstream preloaded with 0x11,0x22,0x33,0x44; Out_Ready=1.
- Response: four consecutive Out_Valid cycles; Sop on 0x11, Eop on 0x44; FOutN low for exactly 4 cycles.
REQ-030 SHALL cover backpressure.
- Stimulus: 4 words available; Out_Ready=0 for 5 cycles, then 1.
- Response: FOutN low for 2 cycles then high; Out_Data held at word 0; all 4 words delivered in order after release.
REQ-031 SHALL cover an empty upstream.
- Stimulus: F_EmptyN=0 throughout.
- Response: FOutN=1 and Out_Valid=0 every cycle.
REQ-032 SHALL cover clear mid-burst.
- Stimulus: 2 of 4 burst words delivered, 1 buffered; DClrN=0 for one cycle.
- Response: Out_Valid=0 next cycle; the next delivered word carries Sop.
REQ-033 SHALL cover reset mid-operation.
- Stimulus: RstN pulsed low asynchronously while the buffer is in state TWO.
- Response: Out_Valid=0 and FOutN=1 immediately.
REQ-034 SHALL cover parity.
- Stimulus: FIFO_DRAIN_PARITY_EN defined; word 0x00000001, then 0x00000003.
- Response: Out_Par=0, then Out_Par=1.

Source files
------------

// File: rtl/fifo_drain.sv
// -----------------------------------------------------------------------------
// fifo_drain
// Drains an upstream show-ahead FIFO into a ready/valid stream, tagging words
// with start/end-of-burst markers every BURST_LEN words. A 2-entry in-order
// buffer lets the read strobe keep running at full rate while the downstream
// is ready, and absorbs the one word in flight when it stalls.
//
// Parameters
//   DWIDTH     data word width (matches the upstream FIFO)
//   BURST_LEN  words per burst, 2..256
//
// Ports
//   Clk        clock, rising edge
//   RstN       asynchronous active-low reset
//   F_Data     upstream FIFO read data (valid at the current read pointer)
//   F_EmptyN   upstream FIFO not-empty
//   FOutN      upstream read strobe, active-low, combinational
//   DClrN      synchronous active-low clear
//   Out_Data   downstream data (buffer head)
//   Out_Valid  downstream valid
//   Out_Ready  downstream ready
//   Out_Sop    first word of a burst
//   Out_Eop    last word of a burst
//   Out_Par    odd parity bit of the head word (only with FIFO_DRAIN_PARITY_EN)
//
// Build option
//   FIFO_DRAIN_PARITY_EN  adds Out_Par and per-entry parity storage
// -----------------------------------------------------------------------------
module fifo_drain #(
  parameter int unsigned DWIDTH    = 32,
  parameter int unsigned BURST_LEN = 4
) (
  input  logic              Clk,
  input  logic              RstN,
  input  logic [DWIDTH-1:0] F_Data,
  input  logic              F_EmptyN,
  output logic              FOutN,
  input  logic              DClrN,
  output logic [DWIDTH-1:0] Out_Data,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic              Out_Sop,
  output logic              Out_Eop
`ifdef FIFO_DRAIN_PARITY_EN
  ,
  output logic              Out_Par
`endif
);

  localparam int unsigned BeatW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BeatW-1:0] LastBeat = BeatW'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } bufState_t;

  // One buffered word with its burst tags (and parity when enabled)
  typedef struct packed {
    logic [DWIDTH-1:0] data;
    logic              sop;
    logic              eop;
`ifdef FIFO_DRAIN_PARITY_EN
    logic              par;
`endif
  } entry_t;

  bufState_t        state;
  bufState_t        stateNext;
  entry_t           head;
  entry_t           headNext;
  entry_t           tail;
  entry_t           tailNext;
  entry_t           newEntry;
  logic [BeatW-1:0] beatCnt;
  logic [BeatW-1:0] beatNext;
  logic             readEn;
  logic             push;
  logic             pop;

  // Tag the incoming word from the current beat position
  always_comb begin
    newEntry      = '0;
    newEntry.data = F_Data;
    newEntry.sop  = (beatCnt == '0);
    newEntry.eop  = (beatCnt == LastBeat);
`ifdef FIFO_DRAIN_PARITY_EN
    // Parity bit makes the total count of ones odd
    newEntry.par  = ~^F_Data;
`endif
  end

  // State, buffer and beat counter registers
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state   <= EMPTY;
      head    <= '0;
      tail    <= '0;
      beatCnt <= '0;
    end else begin
      state   <= stateNext;
      head    <= headNext;
      tail    <= tailNext;
      beatCnt <= beatNext;
    end
  end

  // Next-state, buffer moves and read strobe
  always_comb begin
    stateNext = state;
    headNext  = head;
    tailNext  = tail;
    beatNext  = beatCnt;
    // A read is only safe if a slot frees up this edge when the buffer is full;
    // RstN gates it so the strobe is released the moment reset asserts.
    readEn    = RstN & F_EmptyN & DClrN & ((state != TWO) | Out_Ready);
    push      = readEn;
    pop       = (state != EMPTY) & Out_Ready;
    FOutN     = ~readEn;

    if (!DClrN) begin
      stateNext = EMPTY;
      headNext  = '0;
      tailNext  = '0;
      beatNext  = '0;
    end else begin
      if (push) begin
        beatNext = (beatCnt == LastBeat) ? '0 : beatCnt + BeatW'(1);
      end

      case (state)
        EMPTY: begin
          if (push) begin
            headNext  = newEntry;
            stateNext = ONE;
          end
        end
        ONE: begin
          case ({push, pop})
            2'b10: begin
              tailNext  = newEntry;
              stateNext = TWO;
            end
            2'b01: stateNext = EMPTY;
            2'b11: headNext = newEntry;
            default: stateNext = ONE;
          endcase
        end
        TWO: begin
          // Push cannot occur here without a pop, so no overflow case
          if (pop) begin
            headNext  = tail;
            stateNext = ONE;
            if (push) begin
              tailNext  = newEntry;
              stateNext = TWO;
            end
          end
        end
        default: stateNext = EMPTY;
      endcase
    end
  end

  // Head drives the stream; tags are masked when nothing is held
  assign Out_Valid = (state != EMPTY);
  assign Out_Data  = head.data;
  assign Out_Sop   = head.sop & Out_Valid;
  assign Out_Eop   = head.eop & Out_Valid;
`ifdef FIFO_DRAIN_PARITY_EN
  assign Out_Par   = head.par & Out_Valid;
`endif

endmodule
